// File: rtl/traffic_intersection_pkg.sv
// traffic_light_package: shared FSM state encoding and phase-timer count type
package traffic_light_package;
  // 3-bit encoding leaves 4..7 unused so a corrupted register is detectable
  typedef enum logic [2:0] {
    ALL_RED = 3'd0,
    GREEN   = 3'd1,
    YELLOW  = 3'd2,
    FLASH   = 3'd3
  } state_t;
  localparam int CNT_W = 16;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/traffic_intersection_timer.sv
// phase_timer: loadable down-counter that holds at zero and flags it
module phase_timer
  import traffic_light_package::*;
#(
  parameter cnt_t RST_VAL = '0
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic load,
  input  cnt_t load_val,
  output logic zero
);
  cnt_t count;
  assign zero = count == '0;
  // load wins over decrement; reset restarts at the first state's duration
  always_ff @(posedge clk_i)
    if (!rstn_i) count <= RST_VAL;
    else if (load) count <= load_val;
    else if (!zero) count <= count - cnt_t'(1);
endmodule

// File: rtl/traffic_intersection.sv
// traffic_intersection: round-robin signal controller with flash mode; TRAFFIC_INTERSECTION_PED_EN adds walk requests
module traffic_intersection
  import traffic_light_package::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int CYC_GREEN  = 20,
  parameter int CYC_YELLOW = 2,
  parameter int CYC_ALLRED = 2,
  parameter int CYC_FLASH  = 4,
  parameter int CYC_PED    = 10
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          flash_i,
`ifdef TRAFFIC_INTERSECTION_PED_EN
  input  logic [NUM_PHASES-1:0]         ped_req_i,
  output logic [NUM_PHASES-1:0]         walk_o,
`endif
  output logic [NUM_PHASES-1:0]         red_o,
  output logic [NUM_PHASES-1:0]         yellow_o,
  output logic [NUM_PHASES-1:0]         green_o,
  output logic [$clog2(NUM_PHASES)-1:0] phase_o,
  output logic                          bad_state_o
);
  localparam int PW = $clog2(NUM_PHASES);
  state_t state, state_next;
  logic [PW-1:0] phase, phase_nx;
  logic [NUM_PHASES-1:0] sel, sel_nx;
  logic zero, load, enter_green, flash_on, ext;
  cnt_t load_val;
  assign phase_o = phase;
  assign sel     = NUM_PHASES'(1) << phase;
  assign sel_nx  = NUM_PHASES'(1) << phase_nx;
  phase_timer #(.RST_VAL(cnt_t'(CYC_ALLRED - 1))) u_timer (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );
  // next state, phase advance and timer reload; illegal encodings fall back to ALL_RED
  always_comb begin
    state_next = ALL_RED;
    case (state)
      ALL_RED: state_next = flash_i ? FLASH : zero ? GREEN : ALL_RED;
      GREEN:   state_next = (flash_i || zero) ? YELLOW : GREEN;
      YELLOW:  state_next = zero ? (flash_i ? FLASH : ALL_RED) : YELLOW;
      FLASH:   state_next = flash_i ? FLASH : ALL_RED;
      default: state_next = ALL_RED;
    endcase
    enter_green = state == ALL_RED && state_next == GREEN;
    phase_nx = enter_green ? (phase == PW'(NUM_PHASES - 1) ? '0 : phase + 1'b1)
             : (state == FLASH && state_next == ALL_RED) ? PW'(NUM_PHASES - 1) : phase;
    load = state_next != state || zero;
    load_val = state_next == GREEN  ? cnt_t'(CYC_GREEN - 1) + (ext ? cnt_t'(CYC_PED) : '0)
             : state_next == YELLOW ? cnt_t'(CYC_YELLOW - 1)
             : state_next == FLASH  ? cnt_t'(CYC_FLASH - 1)
             : cnt_t'(CYC_ALLRED - 1);
  end
  // state and phase registers; last-served phase starts at the top so phase 0 goes first
  always_ff @(posedge clk_i)
    if (!rstn_i) begin
      state <= ALL_RED;
      phase <= PW'(NUM_PHASES - 1);
    end else begin
      state <= state_next;
      phase <= phase_nx;
    end
  // flash lamp phase: on at FLASH entry, flips each time the half-period expires
  always_ff @(posedge clk_i)
    if (!rstn_i) flash_on <= 1'b0;
    else flash_on <= state_next != FLASH ? 1'b0 : state != FLASH ? 1'b1 : flash_on ^ zero;
  // lamp decode; anything outside GREEN/YELLOW/FLASH shows all red
  always_comb begin
    red_o = '1;
    yellow_o = '0;
    green_o = '0;
    bad_state_o = 1'b0;
    case (state)
      GREEN:   begin green_o = sel; red_o = ~sel; end
      YELLOW:  begin yellow_o = sel; red_o = ~sel; end
      FLASH:   begin red_o = '0; yellow_o = {NUM_PHASES{flash_on}}; end
      ALL_RED: bad_state_o = 1'b0;
      default: bad_state_o = 1'b1;
    endcase
  end
`ifdef TRAFFIC_INTERSECTION_PED_EN
  logic [NUM_PHASES-1:0] pend;
  logic walk_on;
  assign ext = pend[phase_nx];
  assign walk_o = (state == GREEN && walk_on) ? sel : '0;
  // latch requests; the served phase clears only on its green entry, so a request during its own green waits a turn
  always_ff @(posedge clk_i)
    if (!rstn_i) begin
      pend <= '0;
      walk_on <= 1'b0;
    end else begin
      pend <= (pend & ~(enter_green ? sel_nx : '0)) | ped_req_i;
      walk_on <= enter_green ? pend[phase_nx] : state_next == GREEN && walk_on;
    end
`else
  assign ext = 1'b0;
`endif
endmodule

// File: tb/tb_traffic_intersection.sv
// tb_traffic_intersection: directed checks of sequencing, flash, reset, illegal state and walk extension
module tb_traffic_intersection;
  import traffic_light_package::*;
  localparam int N = 4, G = 20, Y = 2, AR = 2, F = 4, P = 10;
  logic clk = 1'b0, rstn = 1'b0, flash = 1'b0;
  logic [N-1:0] red, yellow, green;
  logic [1:0] phase;
  logic bad;
`ifdef TRAFFIC_INTERSECTION_PED_EN
  logic [N-1:0] ped = '0, walk;
`endif
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  traffic_intersection dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .flash_i     (flash),
`ifdef TRAFFIC_INTERSECTION_PED_EN
    .ped_req_i   (ped),
    .walk_o      (walk),
`endif
    .red_o       (red),
    .yellow_o    (yellow),
    .green_o     (green),
    .phase_o     (phase),
    .bad_state_o (bad)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    flash = 1'b0;
    do_reset();
    vectors++;
    if ({red, yellow, green, phase, bad} !== {4'hF, 4'h0, 4'h0, 2'd3, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: got r=%b y=%b g=%b ph=%0d bad=%b, want r=1111 y=0000 g=0000 ph=3 bad=0", red, yellow, green, phase, bad);
    end
`ifdef TRAFFIC_INTERSECTION_PED_EN
    vectors++;
    if (walk !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_walk: got %b want 0000", walk);
    end
`endif
  endtask

  task automatic test_first_cycle;
    step();
    vectors++;
    if ({red, yellow, green} !== {4'hF, 4'h0, 4'h0}) begin
      miscompares++;
      $display("FAIL first_allred: got r=%b y=%b g=%b want 1111/0000/0000", red, yellow, green);
    end
    for (int i = 0; i < G; i++) begin
      step();
      vectors++;
      if ({red, yellow, green, phase} !== {4'hE, 4'h0, 4'h1, 2'd0}) begin
        miscompares++;
        $display("FAIL first_green[%0d]: got r=%b y=%b g=%b ph=%0d want 1110/0000/0001 ph=0", i, red, yellow, green, phase);
      end
    end
    for (int i = 0; i < Y; i++) begin
      step();
      vectors++;
      if ({red, yellow, green} !== {4'hE, 4'h1, 4'h0}) begin
        miscompares++;
        $display("FAIL first_yellow[%0d]: got r=%b y=%b g=%b want 1110/0001/0000", i, red, yellow, green);
      end
    end
    for (int i = 0; i < AR; i++) begin
      step();
      vectors++;
      if ({red, yellow, green} !== {4'hF, 4'h0, 4'h0}) begin
        miscompares++;
        $display("FAIL first_clear[%0d]: got r=%b y=%b g=%b want 1111/0000/0000", i, red, yellow, green);
      end
    end
    step();
    vectors++;
    if ({red, yellow, green, phase} !== {4'hD, 4'h0, 4'h2, 2'd1}) begin
      miscompares++;
      $display("FAIL second_green: got r=%b y=%b g=%b ph=%0d want 1101/0000/0010 ph=1", red, yellow, green, phase);
    end
  endtask

  task automatic test_rotation;
    logic [N-1:0] s;
    do_reset();
    step();
    for (int r = 0; r < 4 * N + 1; r++) begin
      s = 4'(1 << (r % N));
      for (int i = 0; i < G; i++) begin
        step();
        vectors++;
        if ({red, yellow, green, phase} !== {~s, 4'h0, s, 2'(r % N)} || !$onehot0(green | yellow)) begin
          miscompares++;
          $display("FAIL rot_green r%0d c%0d: got r=%b y=%b g=%b ph=%0d want g=%b ph=%0d", r, i, red, yellow, green, phase, s, r % N);
        end
      end
      if (r == 4 * N) break;
      for (int i = 0; i < Y; i++) begin
        step();
        vectors++;
        if ({red, yellow, green} !== {~s, s, 4'h0} || !$onehot0(green | yellow)) begin
          miscompares++;
          $display("FAIL rot_yellow r%0d c%0d: got r=%b y=%b g=%b want y=%b", r, i, red, yellow, green, s);
        end
      end
      for (int i = 0; i < AR; i++) begin
        step();
        vectors++;
        if ({red, yellow, green} !== {4'hF, 4'h0, 4'h0}) begin
          miscompares++;
          $display("FAIL rot_clear r%0d c%0d: got r=%b y=%b g=%b want 1111/0000/0000", r, i, red, yellow, green);
        end
      end
    end
  endtask

  task automatic test_flash;
    logic [N-1:0] ey;
    step(Y + AR + 5);
    vectors++;
    if ({green, phase} !== {4'h2, 2'd1}) begin
      miscompares++;
      $display("FAIL flash_setup: got g=%b ph=%0d want 0010 ph=1", green, phase);
    end
    flash = 1'b1;
    for (int i = 0; i < Y; i++) begin
      step();
      vectors++;
      if ({red, yellow, green} !== {4'hD, 4'h2, 4'h0}) begin
        miscompares++;
        $display("FAIL flash_yellow[%0d]: got r=%b y=%b g=%b want 1101/0010/0000", i, red, yellow, green);
      end
    end
    for (int k = 0; k < 3; k++) begin
      ey = (k % 2 == 0) ? 4'hF : 4'h0;
      for (int j = 0; j < F; j++) begin
        step();
        vectors++;
        if ({red, yellow, green} !== {4'h0, ey, 4'h0}) begin
          miscompares++;
          $display("FAIL flash_blink h%0d c%0d: got r=%b y=%b g=%b want 0000/%b/0000", k, j, red, yellow, green, ey);
        end
      end
    end
    flash = 1'b0;
    for (int i = 0; i < AR; i++) begin
      step();
      vectors++;
      if ({red, yellow, green, phase} !== {4'hF, 4'h0, 4'h0, 2'd3}) begin
        miscompares++;
        $display("FAIL flash_exit_clear[%0d]: got r=%b y=%b g=%b ph=%0d want 1111/0000/0000 ph=3", i, red, yellow, green, phase);
      end
    end
    step();
    vectors++;
    if ({green, phase} !== {4'h1, 2'd0}) begin
      miscompares++;
      $display("FAIL flash_exit_green: got g=%b ph=%0d want 0001 ph=0", green, phase);
    end
  endtask

  task automatic test_reset_mid_yellow;
    step(G);
    vectors++;
    if (yellow !== 4'h1) begin
      miscompares++;
      $display("FAIL midy_setup: got y=%b want 0001", yellow);
    end
    rstn = 1'b0;
    step();
    vectors++;
    if ({red, yellow, green, phase} !== {4'hF, 4'h0, 4'h0, 2'd3}) begin
      miscompares++;
      $display("FAIL midy_reset: got r=%b y=%b g=%b ph=%0d want 1111/0000/0000 ph=3", red, yellow, green, phase);
    end
    rstn = 1'b1;
    step();
    vectors++;
    if ({red, green} !== {4'hF, 4'h0}) begin
      miscompares++;
      $display("FAIL midy_clear: got r=%b g=%b want 1111/0000", red, green);
    end
    step();
    vectors++;
    if ({green, phase} !== {4'h1, 2'd0}) begin
      miscompares++;
      $display("FAIL midy_restart: got g=%b ph=%0d want 0001 ph=0", green, phase);
    end
  endtask

  task automatic test_bad_state;
    @(negedge clk);
    force dut.state = state_t'(3'd5);
    #1;
    vectors++;
    if ({bad, red, yellow, green} !== {1'b1, 4'hF, 4'h0, 4'h0}) begin
      miscompares++;
      $display("FAIL bad_detect: got bad=%b r=%b y=%b g=%b want 1/1111/0000/0000", bad, red, yellow, green);
    end
    release dut.state;
    @(posedge clk);
    #1;
    vectors++;
    if ({bad, red, dut.state} !== {1'b0, 4'hF, ALL_RED}) begin
      miscompares++;
      $display("FAIL bad_recover: got bad=%b r=%b st=%0d want 0/1111 st=0", bad, red, dut.state);
    end
    step();
    vectors++;
    if (red !== 4'hF) begin
      miscompares++;
      $display("FAIL bad_clear: got r=%b want 1111", red);
    end
    step();
    vectors++;
    if ({green, phase} !== {4'h2, 2'd1}) begin
      miscompares++;
      $display("FAIL bad_resume: got g=%b ph=%0d want 0010 ph=1", green, phase);
    end
  endtask

`ifdef TRAFFIC_INTERSECTION_PED_EN
  task automatic test_ped;
    logic [N-1:0] s;
    int len;
    do_reset();
    step(2);
    ped = 4'b0100;
    step();
    ped = 4'b0000;
    step(G - 2 + Y + AR);
    for (int p = 1; p < N; p++) begin
      s = 4'(1 << p);
      len = (p == 2) ? G + P : G;
      for (int i = 0; i < len; i++) begin
        step();
        vectors++;
        if ({green, walk, phase} !== {s, (p == 2) ? s : 4'h0, 2'(p)}) begin
          miscompares++;
          $display("FAIL ped_green p%0d c%0d: got g=%b walk=%b ph=%0d want g=%b walk=%b", p, i, green, walk, phase, s, (p == 2) ? s : 4'h0);
        end
      end
      step();
      vectors++;
      if ({yellow, walk} !== {s, 4'h0}) begin
        miscompares++;
        $display("FAIL ped_len p%0d: got y=%b walk=%b want y=%b walk=0000", p, yellow, walk, s);
      end
      step(Y - 1 + AR);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_cycle();
    test_rotation();
    test_flash();
    test_reset_mid_yellow();
    test_bad_state();
`ifdef TRAFFIC_INTERSECTION_PED_EN
    test_ped();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
